i2s_transmitter: RTL and testbench
==================================

Name: i2s_transmitter

Overview:
- I2S master transmitter: drives sclk_out, ws_out and sdata_out towards an external I2S DAC/amplifier.
- Takes 16-bit samples from the audio pipeline over a valid/ready handshake and sends each sample on both the left and right slot of one frame.
- Outbound counterpart of the microphone I2S receiver; lives in the same clk_in domain.

Parameters:
- CLK_DIV, 16, clk_in cycles per sclk half-period; CLK_DIV ≥ 2. 100 MHz / (2·16·64) = 48.828 kHz frame rate.
- SAMPLE_WIDTH, 16, sample bits sent MSB-first in each 32-bit slot.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  synchronous, active-low reset
- data_in  input  SAMPLE_WIDTH  two's-complement sample
- data_valid_in  input  1  data_in valid
- ready_out  output  1  holding buffer empty; transfer occurs when data_valid_in && ready_out at a clk_in edge
- sclk_out  output  1  I2S bit clock
- ws_out  output  1  word select; 0 = left, 1 = right
- sdata_out  output  1  serial data, changes only on sclk falling edges
- underrun_out  output  1  one-cycle pulse when a frame starts with an empty buffer

Behaviour:
- Reset (rst_in == 0 at a clk_in edge):
  - div_cnt = 0, sclk_out = 0, ws_out = 0, sdata_out = 0, underrun_out = 0, ready_out = 0.
  - Buffer empty, frame sample = 0, bit counter k = 63.
  - The first cycle after reset release registers ready_out = 1.
- Divider:
  - div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and sclk_out toggles.
  - The 1→0 toggle is the "fall event". First fall event occurs 2·CLK_DIV cycles after reset release.
- Fall event, all updates registered together:
  - k ← (k+1) mod 64.
  - ws_out ← new k[5].
  - j = (k−1) mod 64, computed from the new k.
  - sdata_out ← frame_sample[SAMPLE_WIDTH−1 − (j mod 32)] if (j mod 32) < SAMPLE_WIDTH, else 0.
  - Result: left MSB at k = 1, one sclk after ws falls at k = 0. Right MSB at k = 33, one sclk after ws rises at k = 32. Bits 16..31 of each slot are zero.
- Frame load, at the fall event where the new k = 0:
  - sdata_out for this event uses the old frame sample (right-slot pad, value 0).
  - Then frame_sample ← buffer if the buffer is full; the buffer empties and ready_out goes to 1 next cycle.
  - If the buffer is empty: underrun_out pulses and frame_sample ← 0.
- Handshake:
  - ready_out = registered !buffer_full.
  - Accept: buffer ← data_in; ready_out = 0 from the next cycle.
  - data_in is ignored while ready_out = 0.
- Simultaneous events:
  - Accept in the same cycle as an empty-buffer frame load counts as an underrun. The new sample stays in the buffer for the next frame.
  - Load with the buffer full: no accept is possible, because ready_out = 0.
- Reset mid-frame: everything returns to reset values within one cycle and the buffered sample is discarded.
- Latency: a sample accepted before frame load F appears on sdata_out MSB at k = 1 of frame F.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_HOLD_EN.
- Defined: on underrun, frame_sample keeps its previous value, so the last sample repeats. underrun_out still pulses.
- Undefined: on underrun, frame_sample ← 0 (silence).

Decomposition:
- Shared package i2s_pkg:
  - localparams SLOT_BITS = 32 and FRAME_BITS = 64.
  - typedef sample_t = logic signed [15:0].
  - The receiver uses the same package.
- Sub-module i2s_clk_gen: divider, sclk_out, and a fall-event strobe. Parameter CLK_DIV. Reusable by i2s_receiver.

Test Plan:
- Reset release with no input:
  - First sclk rise at cycle 16, first fall at cycle 32.
  - ws_out period = 2048 cycles; sdata_out always 0.
  - underrun_out pulses once per frame.
- Single sample 16'hA5C3 accepted before the first frame load:
  - Left slot k = 1..16 and right slot k = 33..48 each carry 1010_0101_1100_0011.
  - Remaining bits are 0; no underrun in that frame.
- Back-to-back valid with samples 16'h8001 then 16'h7FFF:
  - ready_out drops after the first accept; the second sample is held off until the frame load.
  - Frames carry 8001 then 7FFF.
- Valid asserted in the exact cycle of an empty-buffer frame load:
  - underrun_out pulses and that frame is silent.
  - The next frame carries the sample.
- Assert rst_in low at k = 20 with the buffer full:
  - All outputs take reset values next cycle; ready_out = 1 one cycle after release.
  - The first frame underruns.
- With I2S_TX_UNDERRUN_HOLD_EN defined: send 16'h1234 once, then no more input.
  - Every subsequent frame repeats 1234 while underrun_out keeps pulsing.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S framing definitions for the transmitter and the microphone receiver.
// A frame is 64 sclk periods: left slot (k = 0..31), then right slot (k = 32..63).
package i2s_pkg;

  localparam int SLOT_BITS   = 32;
  localparam int FRAME_BITS  = 64;
  localparam int SLOT_POS_W  = $clog2(SLOT_BITS);
  localparam int FRAME_POS_W = $clog2(FRAME_BITS);

  typedef logic signed [15:0]      sample_t;
  typedef logic [FRAME_POS_W-1:0]  frame_pos_t;
  typedef logic [SLOT_POS_W-1:0]   slot_pos_t;

  // Word select follows the slot: 0 in the left half of the frame, 1 in the right.
  function automatic logic slot_ws(input frame_pos_t k);
    return k[FRAME_POS_W-1];
  endfunction

  function automatic slot_pos_t slot_pos(input frame_pos_t k);
    return k[SLOT_POS_W-1:0];
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock generator: divides clk_in by 2*CLK_DIV and flags the sclk falling edge.
// fall_evt is high in the clk_in cycle whose edge drives sclk_out from 1 to 0.
module i2s_clk_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic sclk_out,
  output logic fall_evt
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = (div_cnt == LAST);
  assign fall_evt = wrap && sclk_out;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      div_cnt  <= '0;
      sclk_out <= 1'b0;
    end else if (wrap) begin
      div_cnt  <= '0;
      sclk_out <= ~sclk_out;
    end else begin
      div_cnt  <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: one buffered sample is sent MSB-first in both slots of a frame.
// Define I2S_TX_UNDERRUN_HOLD_EN to repeat the last sample on underrun instead of silence.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int CLK_DIV      = 16,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic                    data_valid_in,
  output logic                    ready_out,
  output logic                    sclk_out,
  output logic                    ws_out,
  output logic                    sdata_out,
  output logic                    underrun_out
);

  logic                    fall_evt;
  frame_pos_t              k, k_nxt;
  slot_pos_t               j_slot;
  logic [SAMPLE_WIDTH-1:0] frame_sample, buf_data, tx_shift;
  logic                    buf_full, buf_full_nxt;
  logic                    accept, frame_load, tx_bit;

  i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sclk_out (sclk_out),
    .fall_evt (fall_evt)
  );

  assign k_nxt      = k + frame_pos_t'(1);
  assign frame_load = fall_evt && (k_nxt == '0);
  assign accept     = data_valid_in && ready_out;

  // The bit for new position k+1 is slot index (k+1-1) = old k, so the old k indexes directly.
  // Shifting past the sample width yields the zero padding of the slot tail for free.
  assign j_slot   = slot_pos(k);
  assign tx_shift = frame_sample << j_slot;
  assign tx_bit   = tx_shift[SAMPLE_WIDTH-1];

  always_comb begin
    buf_full_nxt = buf_full;
    if (frame_load) buf_full_nxt = 1'b0;
    if (accept)     buf_full_nxt = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      k            <= frame_pos_t'(FRAME_BITS - 1);
      ws_out       <= 1'b0;
      sdata_out    <= 1'b0;
      underrun_out <= 1'b0;
      ready_out    <= 1'b0;
      buf_full     <= 1'b0;
      buf_data     <= '0;
      frame_sample <= '0;
    end else begin
      underrun_out <= 1'b0;
      if (fall_evt) begin
        k         <= k_nxt;
        ws_out    <= slot_ws(k_nxt);
        sdata_out <= tx_bit;
      end
      // Load happens after this edge's bit was chosen from the old sample (pad bit, zero).
      if (frame_load) begin
        if (buf_full) begin
          frame_sample <= buf_data;
        end else begin
          underrun_out <= 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
          frame_sample <= frame_sample;
`else
          frame_sample <= '0;
`endif
        end
      end
      if (accept) buf_data <= data_in;
      buf_full  <= buf_full_nxt;
      ready_out <= !buf_full_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: directed scenarios plus random traffic,
// checked every cycle against a frame-level arithmetic model of the I2S stream.
module tb_i2s_transmitter;

  localparam int D         = 16;
  localparam int SW        = 16;
  localparam int FRAME_CYC = 2 * D * 64;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [SW-1:0] data_in;
  logic          data_valid_in;
  logic          ready_out, sclk_out, ws_out, sdata_out, underrun_out;

  always #5 clk_in = ~clk_in;

  i2s_transmitter #(.CLK_DIV(D), .SAMPLE_WIDTH(SW)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .ready_out     (ready_out),
    .sclk_out      (sclk_out),
    .ws_out        (ws_out),
    .sdata_out     (sdata_out),
    .underrun_out  (underrun_out)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n;          // clk_in edges since reset release
  bit            bfull, exp_ready, exp_und, last_acc;
  logic [SW-1:0] bval, fval; // buffered sample, sample of the frame on the wire

  function automatic bit is_load(input int nn);
    return (nn >= 2 * D) && ((nn - 2 * D) % FRAME_CYC == 0);
  endfunction

  function automatic logic exp_sclk(input int nn);
    return ((nn / D) % 2) == 1;
  endfunction

  function automatic int frame_pos(input int nn);
    return ((nn / (2 * D)) - 1) % 64;
  endfunction

  function automatic logic exp_ws(input int nn);
    if (nn < 2 * D) return 1'b0;
    return frame_pos(nn) >= 32;
  endfunction

  // Slot position p = 1..SW carries sample bit SW-p; everything else is zero.
  function automatic logic exp_sdata(input int nn, input logic [SW-1:0] s);
    int p;
    logic [SW-1:0] t;
    if (nn < 2 * D) return 1'b0;
    p = frame_pos(nn) % 32;
    if (p < 1 || p > SW) return 1'b0;
    t = s >> (SW - p);
    return t[0];
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at n=%0d: observed %b expected %b", tag, n, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic vld, input logic [SW-1:0] d);
    rst_in = rst; data_valid_in = vld; data_in = d;
    @(posedge clk_in);
    last_acc = 0;
    exp_und  = 0;
    if (!rst) begin
      n = 0; bfull = 0; exp_ready = 0; fval = '0;
    end else begin
      n++;
      if (is_load(n)) begin
        if (bfull) begin
          fval  = bval;
          bfull = 0;
        end else begin
          exp_und = 1;
`ifndef I2S_TX_UNDERRUN_HOLD_EN
          fval = '0;
`endif
        end
      end
      if (vld && exp_ready) begin
        bval = d; bfull = 1; last_acc = 1;
      end
      exp_ready = !bfull;
    end
    #1;
    check("sclk",     sclk_out,     exp_sclk(n));
    check("ws",       ws_out,       exp_ws(n));
    check("sdata",    sdata_out,    exp_sdata(n, fval));
    check("ready",    ready_out,    exp_ready);
    check("underrun", underrun_out, exp_und);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step(1'b1, 1'b0, '0);
  endtask

  task automatic send(input logic [SW-1:0] d);
    int t = 0;
    do begin
      step(1'b1, 1'b1, d);
      t++;
    end while (!last_acc && t < 2 * FRAME_CYC);
    if (!last_acc) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout: sample %h not accepted within %0d cycles", d, t);
    end
  endtask

  task automatic wait_until_after_load();
    int t = 0;
    while (!is_load(n) && t < 2 * FRAME_CYC) begin
      idle(1);
      t++;
    end
  endtask

  initial begin
    rst_in = 1'b0; data_valid_in = 1'b0; data_in = '0;
    n = 0; bfull = 0; exp_ready = 0; exp_und = 0; last_acc = 0; bval = '0; fval = '0;

    // Reset state, then two idle frames: underrun each frame, silent data.
    repeat (3) step(1'b0, 1'b0, '0);
    idle(2 * D + 2 * FRAME_CYC + 10);

    // Single sample before the first frame load.
    repeat (2) step(1'b0, 1'b0, '0);
    send(16'hA5C3);
    idle(2 * D + FRAME_CYC + 50 - n);

    // Back-to-back: second sample held off until the next frame load.
    send(16'h8001);
    send(16'h7FFF);
    idle(2 * FRAME_CYC + 20);

    // Valid in the exact cycle of an empty-buffer load.
    begin
      int t = 0;
      while (!is_load(n + 1) && t < 2 * FRAME_CYC) begin
        idle(1);
        t++;
      end
    end
    step(1'b1, 1'b1, 16'h3C96);
    idle(2 * FRAME_CYC + 20);

    // Random traffic, including valid while not ready.
    repeat (3 * FRAME_CYC)
      step(1'b1, $urandom_range(0, 1499) == 0, SW'($urandom));

    // Reset at k = 20 with the buffer full.
    wait_until_after_load();
    send(16'h5A5A);
    begin
      int t = 0;
      while (!(n % (2 * D) == 0 && frame_pos(n) == 20) && t < FRAME_CYC) begin
        idle(1);
        t++;
      end
    end
    repeat (2) step(1'b0, 1'b0, '0);
    idle(2 * D + FRAME_CYC + 10);

    // One sample, then starve: silence or repetition depending on the build.
    send(16'h1234);
    idle(3 * FRAME_CYC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
